register_alias_table: RTL and testbench
=======================================

REGISTER_ALIAS_TABLE -- requirements
Module: register_alias_table

Interface
REQ-001 SHALL have no parameters; 32 architectural registers, 32-entry ROB, 5-bit tags fixed.
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  dispatch stalled; no rename, no checkpoint save this cycle.
REQ-005 one_instr  in  1  only slot 0 dispatches this cycle; slot 1 rename ignored.
REQ-006 disp_p  in  5  ROB tag of slot 0; slot 1 tag = disp_p+1 mod 32.
REQ-007 rn_en, rn_en2  in  1 each  slot 0/1 writes a destination register.
REQ-008 rn_dest, rn_dest2  in  5 each  slot 0/1 destination register.
REQ-009 src1, src2, src1_2, src2_2  in  5 each  source registers, slot 0 then slot 1.
REQ-010 busy1, busy2, busy1_2, busy2_2  out  1 each  source produced by in-flight ROB entry.
REQ-011 tag1, tag2, tag1_2, tag2_2  out  5 each  producing ROB tag; 0 when not busy.
REQ-012 commit, commit2  in  1 each  commit port 0/1 retiring a register write.
REQ-013 commit_addr, commit_addr2  in  5 each  retiring destination register.
REQ-014 commit_tag, commit_tag2  in  5 each  retiring ROB tag.
REQ-015 flush  in  1  mispredict recovery request.
REQ-016 ckpt_save  in  1  dispatching branch, snapshot table.
REQ-017 ckpt_valid  out  1  checkpoint held.

Function
REQ-018 Table SHALL hold per register a valid bit and 5-bit tag.
REQ-019 Rename (~stall): rn_en sets entry rn_dest valid, tag disp_p; rn_en2 && ~one_instr sets entry rn_dest2 valid, tag disp_p+1 (wrap 31->0).
REQ-020 Both slots same destination SHALL leave slot 1 mapping.
REQ-021 Register 0 SHALL never be mapped; lookups of r0 give busy=0, tag=0.
REQ-022 Lookups SHALL be combinational from pre-edge table state; busy=valid, tag=valid?tag:0.
REQ-023 Slot 1 sources SHALL bypass: if src equals rn_dest with rn_en && ~stall and nonzero, busy=1, tag=disp_p.
REQ-024 Commit port SHALL clear valid only when entry valid and stored tag equals commit tag; stale commits ignored.
REQ-025 Rename and commit to same register same cycle: rename wins.
REQ-026 Both commit ports same register: clear if either tag matches.
REQ-027 Lookups in a committing cycle SHALL still report pre-commit state (busy=1).
REQ-028 flush SHALL override renames, saves and commits in same cycle; result per Configuration.
REQ-029 No state change when stall=1 except commits and flush.

Reset
REQ-030 rst low SHALL clear all valid bits, tags, checkpoint and ckpt_valid immediately; busy*/tag* read 0.
REQ-031 Reset mid-dispatch SHALL discard in-progress renames; first edge after release behaves as normal.

Configuration
REQ-032 Macro RAT_CHECKPOINT_EN selects single-level checkpoint recovery.
REQ-033 With RAT_CHECKPOINT_EN: ckpt_save && ~stall stores table as updated by that cycle's renames and commits, sets ckpt_valid; commits also clear matching checkpoint entries; flush with ckpt_valid restores table from checkpoint and clears ckpt_valid; flush without ckpt_valid clears all valid; save during held checkpoint overwrites it.
REQ-034 Without RAT_CHECKPOINT_EN: no checkpoint storage; ckpt_save ignored; ckpt_valid tied 0; flush clears all valid bits.

Verification
REQ-035 Rename r5 tag 3 then lookup src1=5 -> busy1=1, tag1=3; commit r5 tag 3 -> next cycle busy1=0, tag1=0.
REQ-036 Slot0 rn_dest=7, disp_p=31; slot1 rn_dest=7, src1_2=7 -> busy1_2=1, tag1_2=31; next cycle r7 tag=0.
REQ-037 r9 renamed tag 4 then tag 6; commit r9 tag 4 -> r9 stays busy, tag 6.
REQ-038 Same cycle rename r2 tag 10 and commit r2 old tag 8 -> r2 busy tag 10; rn_dest=0 -> r0 lookup busy=0.
REQ-039 RAT_CHECKPOINT_EN: r3 tag 1, save, rename r3 tag 2, commit r3 tag 1, flush -> r3 not busy, ckpt_valid=0; macro off: flush clears all.
REQ-040 Assert rst low mid-stream with renames pending -> all busy*=0, ckpt_valid=0 same cycle.

Source files
------------

// File: rtl/register_alias_table_if.sv
// Rename/lookup/commit/recovery signal bundle between dispatch and the register alias table.
interface register_alias_table_if;
  logic       stall;
  logic       one_instr;
  logic [4:0] disp_p;
  logic       rn_en;
  logic       rn_en2;
  logic [4:0] rn_dest;
  logic [4:0] rn_dest2;
  logic [4:0] src1;
  logic [4:0] src2;
  logic [4:0] src1_2;
  logic [4:0] src2_2;
  logic       busy1;
  logic       busy2;
  logic       busy1_2;
  logic       busy2_2;
  logic [4:0] tag1;
  logic [4:0] tag2;
  logic [4:0] tag1_2;
  logic [4:0] tag2_2;
  logic       commit;
  logic       commit2;
  logic [4:0] commit_addr;
  logic [4:0] commit_addr2;
  logic [4:0] commit_tag;
  logic [4:0] commit_tag2;
  logic       flush;
  logic       ckpt_save;
  logic       ckpt_valid;

  modport master (
    output stall, one_instr, disp_p, rn_en, rn_en2, rn_dest, rn_dest2,
           src1, src2, src1_2, src2_2,
           commit, commit2, commit_addr, commit_addr2, commit_tag, commit_tag2,
           flush, ckpt_save,
    input  busy1, busy2, busy1_2, busy2_2, tag1, tag2, tag1_2, tag2_2, ckpt_valid
  );

  modport slave (
    input  stall, one_instr, disp_p, rn_en, rn_en2, rn_dest, rn_dest2,
           src1, src2, src1_2, src2_2,
           commit, commit2, commit_addr, commit_addr2, commit_tag, commit_tag2,
           flush, ckpt_save,
    output busy1, busy2, busy1_2, busy2_2, tag1, tag2, tag1_2, tag2_2, ckpt_valid
  );
endinterface

// File: rtl/register_alias_table.sv
// Register alias table: 32 regs, 5-bit ROB tags, 2-wide rename, 2 commit ports.
// Optional single-level checkpoint recovery under RAT_CHECKPOINT_EN.
module register_alias_table (
  input  logic                  clk,
  input  logic                  rst,
  register_alias_table_if.slave rat_bus
);
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned TAG_W    = 5;

  logic [NUM_REGS-1:0]            r_valid;
  logic [NUM_REGS-1:0][TAG_W-1:0] r_tag;
  logic [NUM_REGS-1:0]            w_valid_upd;
  logic [NUM_REGS-1:0][TAG_W-1:0] w_tag_upd;
  logic [NUM_REGS-1:0]            w_valid_nxt;
  logic [NUM_REGS-1:0][TAG_W-1:0] w_tag_nxt;
  logic [TAG_W-1:0]               w_tag_slot1;
  logic                           w_cmt0_hit;
  logic                           w_cmt1_hit;
  logic                           w_byp_en;

  assign w_tag_slot1 = rat_bus.disp_p + TAG_W'(1);

  // Commit matches are judged on the pre-edge table so stale commits are dropped
  always_comb begin
    w_cmt0_hit = rat_bus.commit && r_valid[rat_bus.commit_addr] &&
                 (r_tag[rat_bus.commit_addr] == rat_bus.commit_tag);
    w_cmt1_hit = rat_bus.commit2 && r_valid[rat_bus.commit_addr2] &&
                 (r_tag[rat_bus.commit_addr2] == rat_bus.commit_tag2);
  end

  // Table after commits then renames; later renames override, slot 1 last
  always_comb begin
    w_valid_upd = r_valid;
    w_tag_upd   = r_tag;
    if (w_cmt0_hit) w_valid_upd[rat_bus.commit_addr]  = 1'b0;
    if (w_cmt1_hit) w_valid_upd[rat_bus.commit_addr2] = 1'b0;
    if (!rat_bus.stall) begin
      if (rat_bus.rn_en && (rat_bus.rn_dest != '0)) begin
        w_valid_upd[rat_bus.rn_dest] = 1'b1;
        w_tag_upd[rat_bus.rn_dest]   = rat_bus.disp_p;
      end
      if (rat_bus.rn_en2 && !rat_bus.one_instr && (rat_bus.rn_dest2 != '0)) begin
        w_valid_upd[rat_bus.rn_dest2] = 1'b1;
        w_tag_upd[rat_bus.rn_dest2]   = w_tag_slot1;
      end
    end
  end

`ifdef RAT_CHECKPOINT_EN
  logic [NUM_REGS-1:0]            r_ck_valid;
  logic [NUM_REGS-1:0][TAG_W-1:0] r_ck_tag;
  logic                           r_ckpt_valid;
  logic [NUM_REGS-1:0]            w_ck_valid_nxt;
  logic [NUM_REGS-1:0][TAG_W-1:0] w_ck_tag_nxt;
  logic                           w_ckpt_valid_nxt;
  logic                           w_ck0_hit;
  logic                           w_ck1_hit;

  // Retiring writes also drop out of the snapshot so a restore never resurrects them
  always_comb begin
    w_ck0_hit = rat_bus.commit && r_ck_valid[rat_bus.commit_addr] &&
                (r_ck_tag[rat_bus.commit_addr] == rat_bus.commit_tag);
    w_ck1_hit = rat_bus.commit2 && r_ck_valid[rat_bus.commit_addr2] &&
                (r_ck_tag[rat_bus.commit_addr2] == rat_bus.commit_tag2);
  end

  // Flush restores or clears; otherwise save the updated table or age the snapshot
  always_comb begin
    w_valid_nxt      = w_valid_upd;
    w_tag_nxt        = w_tag_upd;
    w_ck_valid_nxt   = r_ck_valid;
    w_ck_tag_nxt     = r_ck_tag;
    w_ckpt_valid_nxt = r_ckpt_valid;
    if (rat_bus.flush) begin
      if (r_ckpt_valid) begin
        w_valid_nxt = r_ck_valid;
        w_tag_nxt   = r_ck_tag;
      end else begin
        w_valid_nxt = '0;
        w_tag_nxt   = r_tag;
      end
      w_ckpt_valid_nxt = 1'b0;
    end else if (rat_bus.ckpt_save && !rat_bus.stall) begin
      w_ck_valid_nxt   = w_valid_upd;
      w_ck_tag_nxt     = w_tag_upd;
      w_ckpt_valid_nxt = 1'b1;
    end else begin
      if (w_ck0_hit) w_ck_valid_nxt[rat_bus.commit_addr]  = 1'b0;
      if (w_ck1_hit) w_ck_valid_nxt[rat_bus.commit_addr2] = 1'b0;
    end
  end

  // Checkpoint storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ck_valid   <= '0;
      r_ck_tag     <= '0;
      r_ckpt_valid <= 1'b0;
    end else begin
      r_ck_valid   <= w_ck_valid_nxt;
      r_ck_tag     <= w_ck_tag_nxt;
      r_ckpt_valid <= w_ckpt_valid_nxt;
    end
  end

  assign rat_bus.ckpt_valid = r_ckpt_valid;
`else
  logic w_unused_ckpt_save;

  // Without checkpoints a flush simply forgets every in-flight mapping
  always_comb begin
    w_valid_nxt = w_valid_upd;
    w_tag_nxt   = w_tag_upd;
    if (rat_bus.flush) begin
      w_valid_nxt = '0;
      w_tag_nxt   = r_tag;
    end
  end

  assign w_unused_ckpt_save = rat_bus.ckpt_save;
  assign rat_bus.ckpt_valid = 1'b0;
`endif

  // Mapping table state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_tag   <= w_tag_nxt;
    end
  end

  // Slot 1 sees slot 0's destination this cycle; masked in reset so outputs read 0
  assign w_byp_en = rst && !rat_bus.stall && rat_bus.rn_en && (rat_bus.rn_dest != '0);

  // Source lookups from the pre-edge table (r0 is never valid)
  assign rat_bus.busy1 = r_valid[rat_bus.src1];
  assign rat_bus.tag1  = r_valid[rat_bus.src1] ? r_tag[rat_bus.src1] : '0;
  assign rat_bus.busy2 = r_valid[rat_bus.src2];
  assign rat_bus.tag2  = r_valid[rat_bus.src2] ? r_tag[rat_bus.src2] : '0;

  assign rat_bus.busy1_2 = (w_byp_en && (rat_bus.src1_2 == rat_bus.rn_dest)) ||
                           r_valid[rat_bus.src1_2];
  assign rat_bus.tag1_2  = (w_byp_en && (rat_bus.src1_2 == rat_bus.rn_dest)) ? rat_bus.disp_p :
                           r_valid[rat_bus.src1_2] ? r_tag[rat_bus.src1_2] : '0;
  assign rat_bus.busy2_2 = (w_byp_en && (rat_bus.src2_2 == rat_bus.rn_dest)) ||
                           r_valid[rat_bus.src2_2];
  assign rat_bus.tag2_2  = (w_byp_en && (rat_bus.src2_2 == rat_bus.rn_dest)) ? rat_bus.disp_p :
                           r_valid[rat_bus.src2_2] ? r_tag[rat_bus.src2_2] : '0;
endmodule

// File: tb/tb_register_alias_table.sv
// Bench for register_alias_table: directed vector table, recovery/reset sequences,
// and randomized traffic against a behavioural alias-table model.
module tb_register_alias_table;
`ifdef RAT_CHECKPOINT_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  register_alias_table_if bus ();

  register_alias_table dut (
    .clk     (clk),
    .rst     (rst),
    .rat_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, one, e0;
    logic [4:0] d0;
    logic       e1;
    logic [4:0] d1, dp;
    logic       cm;
    logic [4:0] ca, ct, s1, s12;
    logic       xb1;
    logic [4:0] xt1;
    logic       xb12;
    logic [4:0] xt12;
  } vec_t;

  vec_t vt[20];

  // Reference model: architectural register -> in-flight producer, plus snapshot
  bit         m_v[32];
  logic [4:0] m_t[32];
  bit         c_v[32];
  logic [4:0] c_t[32];
  bit         m_ckv;

  function automatic vec_t mk(input int st, one, e0, d0, e1, d1, dp, cm, ca, ct,
                              s1, s12, xb1, xt1, xb12, xt12);
    vec_t v;
    v.st = 1'(st); v.one = 1'(one); v.e0 = 1'(e0); v.d0 = 5'(d0);
    v.e1 = 1'(e1); v.d1 = 5'(d1); v.dp = 5'(dp); v.cm = 1'(cm);
    v.ca = 5'(ca); v.ct = 5'(ct); v.s1 = 5'(s1); v.s12 = 5'(s12);
    v.xb1 = 1'(xb1); v.xt1 = 5'(xt1); v.xb12 = 1'(xb12); v.xt12 = 5'(xt12);
    return v;
  endfunction

  task automatic chk1(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b want=%0b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk5(input string nm, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.one_instr = 1; bus.disp_p = 0;
    bus.rn_en = 0; bus.rn_en2 = 0; bus.rn_dest = 0; bus.rn_dest2 = 0;
    bus.src1 = 0; bus.src2 = 0; bus.src1_2 = 0; bus.src2_2 = 0;
    bus.commit = 0; bus.commit2 = 0; bus.commit_addr = 0; bus.commit_addr2 = 0;
    bus.commit_tag = 0; bus.commit_tag2 = 0; bus.flush = 0; bus.ckpt_save = 0;
  endtask

  function automatic void model_reset();
    foreach (m_v[i]) begin m_v[i] = 0; m_t[i] = 0; c_v[i] = 0; c_t[i] = 0; end
    m_ckv = 0;
  endfunction

  // What a source lookup should report right now
  function automatic void exp_lookup(input logic [4:0] s, input bit slot1,
                                     output bit b, output logic [4:0] t);
    b = m_v[s];
    t = b ? m_t[s] : 5'd0;
    if (slot1 && !bus.stall && bus.rn_en && bus.rn_dest != 0 && s == bus.rn_dest) begin
      b = 1; t = bus.disp_p;
    end
  endfunction

  // Advance the model by one clock using the current inputs
  function automatic void model_step();
    bit         nv[32];
    logic [4:0] nt[32];
    bit         ncv[32];
    logic [4:0] t1;
    if (bus.flush) begin
      if (CK && m_ckv) begin m_v = c_v; m_t = c_t; end
      else foreach (m_v[i]) m_v[i] = 0;
      m_ckv = 0;
      return;
    end
    nv = m_v; nt = m_t; ncv = c_v;
    if (bus.commit  && m_v[bus.commit_addr]  && m_t[bus.commit_addr]  == bus.commit_tag)  nv[bus.commit_addr]  = 0;
    if (bus.commit2 && m_v[bus.commit_addr2] && m_t[bus.commit_addr2] == bus.commit_tag2) nv[bus.commit_addr2] = 0;
    if (bus.commit  && c_v[bus.commit_addr]  && c_t[bus.commit_addr]  == bus.commit_tag)  ncv[bus.commit_addr]  = 0;
    if (bus.commit2 && c_v[bus.commit_addr2] && c_t[bus.commit_addr2] == bus.commit_tag2) ncv[bus.commit_addr2] = 0;
    if (!bus.stall) begin
      t1 = bus.disp_p + 5'd1;
      if (bus.rn_en && bus.rn_dest != 0) begin nv[bus.rn_dest] = 1; nt[bus.rn_dest] = bus.disp_p; end
      if (bus.rn_en2 && !bus.one_instr && bus.rn_dest2 != 0) begin nv[bus.rn_dest2] = 1; nt[bus.rn_dest2] = t1; end
    end
    m_v = nv; m_t = nt;
    if (CK) begin
      if (bus.ckpt_save && !bus.stall) begin c_v = nv; c_t = nt; m_ckv = 1; end
      else c_v = ncv;
    end
  endfunction

  task automatic check_all();
    bit b; logic [4:0] t;
    exp_lookup(bus.src1, 0, b, t);   chk1("busy1", bus.busy1, b);     chk5("tag1", bus.tag1, t);
    exp_lookup(bus.src2, 0, b, t);   chk1("busy2", bus.busy2, b);     chk5("tag2", bus.tag2, t);
    exp_lookup(bus.src1_2, 1, b, t); chk1("busy1_2", bus.busy1_2, b); chk5("tag1_2", bus.tag1_2, t);
    exp_lookup(bus.src2_2, 1, b, t); chk1("busy2_2", bus.busy2_2, b); chk5("tag2_2", bus.tag2_2, t);
    chk1("ckpt_valid", bus.ckpt_valid, m_ckv);
  endtask

  // Check pre-edge outputs, advance model, cross the edge; caller sits at posedge+1
  task automatic tick();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    bus.stall     = ($urandom_range(0, 3) == 0);
    bus.one_instr = ($urandom_range(0, 2) == 0);
    bus.disp_p    = 5'($urandom);
    bus.rn_en     = 1'($urandom);
    bus.rn_en2    = 1'($urandom);
    bus.rn_dest   = 5'($urandom_range(0, 7));
    bus.rn_dest2  = 5'($urandom_range(0, 7));
    bus.src1      = 5'($urandom_range(0, 7));
    bus.src2      = 5'($urandom_range(0, 7));
    bus.src1_2    = 5'($urandom_range(0, 7));
    bus.src2_2    = 5'($urandom_range(0, 7));
    bus.commit       = 1'($urandom);
    bus.commit_addr  = 5'($urandom_range(0, 7));
    bus.commit_tag   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : m_t[bus.commit_addr];
    bus.commit2      = 1'($urandom);
    bus.commit_addr2 = 5'($urandom_range(0, 7));
    bus.commit_tag2  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : m_t[bus.commit_addr2];
    bus.flush     = ($urandom_range(0, 31) == 0);
    bus.ckpt_save = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    idle();
    model_reset();

    //        st one e0 d0 e1 d1 dp  cm ca ct  s1 s12 xb1 xt1 xb12 xt12
    vt[0]  = mk(0, 1, 1, 5, 0, 0, 3,  0, 0, 0,  5, 5,  0, 0,  1, 3);
    vt[1]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 5, 3,  5, 0,  1, 3,  0, 0);
    vt[2]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  5, 5,  0, 0,  0, 0);
    vt[3]  = mk(0, 0, 1, 7, 1, 7, 31, 0, 0, 0,  7, 7,  0, 0,  1, 31);
    vt[4]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  7, 7,  1, 0,  1, 0);
    vt[5]  = mk(0, 1, 1, 9, 0, 0, 4,  0, 0, 0,  9, 0,  0, 0,  0, 0);
    vt[6]  = mk(0, 1, 1, 9, 0, 0, 6,  0, 0, 0,  9, 0,  1, 4,  0, 0);
    vt[7]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 9, 4,  9, 0,  1, 6,  0, 0);
    vt[8]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  9, 9,  1, 6,  1, 6);
    vt[9]  = mk(0, 1, 1, 2, 0, 0, 8,  0, 0, 0,  2, 0,  0, 0,  0, 0);
    vt[10] = mk(0, 1, 1, 2, 0, 0, 10, 1, 2, 8,  2, 0,  1, 8,  0, 0);
    vt[11] = mk(0, 1, 1, 0, 0, 0, 12, 0, 0, 0,  2, 0,  1, 10, 0, 0);
    vt[12] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 2,  0, 0,  1, 10);
    vt[13] = mk(1, 1, 1, 4, 0, 0, 13, 0, 0, 0,  4, 4,  0, 0,  0, 0);
    vt[14] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  4, 9,  0, 0,  1, 6);
    vt[15] = mk(0, 1, 0, 0, 0, 0, 0,  1, 9, 4,  9, 0,  1, 6,  0, 0);
    vt[16] = mk(0, 1, 0, 0, 1, 11, 20, 0, 0, 0, 9, 11, 1, 6,  0, 0);
    vt[17] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 11, 11, 0, 0,  0, 0);
    vt[18] = mk(1, 1, 0, 0, 0, 0, 0,  1, 9, 6,  9, 9,  1, 6,  1, 6);
    vt[19] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  9, 2,  0, 0,  1, 10);

    #2;
    do_reset();

    // Reset state
    @(negedge clk);
    for (int r = 0; r < 32; r++) begin
      bus.src1 = 5'(r);
      #0.1;
      if (r % 8 == 3) chk1($sformatf("rst_busy_r%0d", r), bus.busy1, 1'b0);
    end
    chk5("rst_tag1", bus.tag1, 5'd0);
    chk1("rst_ckpt_valid", bus.ckpt_valid, 1'b0);
    bus.src1 = 0;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      bus.stall = vt[i].st; bus.one_instr = vt[i].one; bus.disp_p = vt[i].dp;
      bus.rn_en = vt[i].e0; bus.rn_dest = vt[i].d0;
      bus.rn_en2 = vt[i].e1; bus.rn_dest2 = vt[i].d1;
      bus.commit = vt[i].cm; bus.commit_addr = vt[i].ca; bus.commit_tag = vt[i].ct;
      bus.src1 = vt[i].s1; bus.src1_2 = vt[i].s12;
      @(negedge clk);
      chk1($sformatf("v%0d_busy1", i), bus.busy1, vt[i].xb1);
      chk5($sformatf("v%0d_tag1", i), bus.tag1, vt[i].xt1);
      chk1($sformatf("v%0d_busy1_2", i), bus.busy1_2, vt[i].xb12);
      chk5($sformatf("v%0d_tag1_2", i), bus.tag1_2, vt[i].xt12);
      @(posedge clk);
      #1;
    end

    // Checkpoint save, stale-vs-snapshot commit, flush
    do_reset();
    idle(); bus.rn_en = 1; bus.rn_dest = 3; bus.disp_p = 1; tick();
    idle(); bus.ckpt_save = 1; tick();
    idle(); bus.src1 = 3;
    @(negedge clk);
    chk1("ck_held", bus.ckpt_valid, CK);
    @(posedge clk); #1;
    idle(); bus.rn_en = 1; bus.rn_dest = 3; bus.disp_p = 2; tick();
    idle(); bus.commit = 1; bus.commit_addr = 3; bus.commit_tag = 1; tick();
    idle(); bus.src1 = 3;
    @(negedge clk);
    chk1("ck_pre_flush_busy", bus.busy1, 1'b1);
    chk5("ck_pre_flush_tag", bus.tag1, 5'd2);
    @(posedge clk); #1;
    idle(); bus.flush = 1; tick();
    idle(); bus.src1 = 3;
    @(negedge clk);
    chk1("ck_flush_r3_busy", bus.busy1, 1'b0);
    chk1("ck_flush_valid", bus.ckpt_valid, 1'b0);
    @(posedge clk); #1;

    // Restore of a live snapshot; flush overrides same-cycle rename and commit
    idle(); bus.rn_en = 1; bus.rn_dest = 6; bus.disp_p = 20; tick();
    idle(); bus.ckpt_save = 1; tick();
    idle(); bus.rn_en = 1; bus.rn_dest = 6; bus.disp_p = 21; tick();
    idle(); bus.flush = 1; bus.commit = 1; bus.commit_addr = 6; bus.commit_tag = 21;
    bus.rn_en = 1; bus.rn_dest = 7; bus.disp_p = 5; tick();
    idle(); bus.src1 = 6; bus.src2 = 7;
    @(negedge clk);
    chk1("restore_r6_busy", bus.busy1, CK);
    chk5("restore_r6_tag", bus.tag1, CK ? 5'd20 : 5'd0);
    chk1("restore_r7_busy", bus.busy2, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      tick();
    end

    // Asynchronous reset mid-dispatch, then a normal first edge
    idle();
    for (int r = 1; r < 8; r++) begin
      bus.rn_en = 1; bus.rn_dest = 5'(r); bus.disp_p = 5'(r + 16); tick();
    end
    bus.ckpt_save = 1; bus.rn_en = 1; bus.rn_dest = 4; bus.disp_p = 9;
    bus.src1 = 2; bus.src2 = 5; bus.src1_2 = 4; bus.src2_2 = 6;
    #2;
    rst = 0;
    #1;
    chk1("arst_busy1", bus.busy1, 1'b0);
    chk1("arst_busy2", bus.busy2, 1'b0);
    chk1("arst_busy1_2", bus.busy1_2, 1'b0);
    chk1("arst_busy2_2", bus.busy2_2, 1'b0);
    chk5("arst_tag1_2", bus.tag1_2, 5'd0);
    chk1("arst_ckpt_valid", bus.ckpt_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1;
    bus.ckpt_save = 0;
    #1;
    check_all();
    model_step();
    @(posedge clk); #1;
    idle(); bus.src1 = 4; bus.src2 = 2;
    @(negedge clk);
    chk1("post_rst_r4_busy", bus.busy1, 1'b1);
    chk5("post_rst_r4_tag", bus.tag1, 5'd9);
    chk1("post_rst_r2_busy", bus.busy2, 1'b0);
    @(posedge clk); #1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
